instr_fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the MIPS control path. Holds the PC, issues word reads to

---
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and the decode/control path.
// The master side is the fetch unit; the slave side is memory plus decode.
interface instr_fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [31:0] pc_plus4;
   logic        pc_source;
   logic        jump;
   logic [31:0] branch_imm;

   modport master (
      output imem_req_valid, imem_addr, instr_valid, instr, op, funct, pc_plus4,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
             pc_source, jump, branch_imm
   );

   modport slave (
      input  imem_req_valid, imem_addr, instr_valid, instr, op, funct, pc_plus4,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
             pc_source, jump, branch_imm
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch: single outstanding imem read, one buffered instruction to decode.
// Optional FETCH_PERF_CNT_EN adds fetch_count / redirect_count performance counters.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   instr_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]         fetch_count,
   output logic [31:0]         redirect_count
`endif
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_FULL = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] instr_q;
   logic        instr_valid_q;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        handshake;

   assign pc_plus4  = pc + 32'd4;
   assign handshake = (state == S_FULL) && bus.instr_ready;

   // NOTE: every signal written in always_comb gets a default first so no path can infer a latch.
   always_comb begin
      next_pc = pc_plus4;
      if (bus.jump)
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      else if (bus.pc_source)
         next_pc = pc_plus4 + (bus.branch_imm << 2);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_REQ;
         pc            <= RESET_PC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (bus.imem_req_ready)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.imem_rsp_valid) begin
                  instr_q       <= bus.imem_rsp_data;
                  instr_valid_q <= 1'b1;
                  state         <= S_FULL;
               end
            end
            // Responses arriving in S_FULL or S_REQ are stale and deliberately dropped.
            S_FULL: begin
               if (bus.instr_ready) begin
                  pc            <= next_pc;
                  instr_valid_q <= 1'b0;
                  state         <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

   // Request is decoded from state but masked during reset so nothing is issued mid-reset.
   assign bus.imem_req_valid = (state == S_REQ) && !reset;
   assign bus.imem_addr      = {pc[31:2], 2'b00};
   assign bus.instr_valid    = instr_valid_q;
   assign bus.instr          = instr_q;
   assign bus.op             = instr_q[31:26];
   assign bus.funct          = instr_q[5:0];
   assign bus.pc_plus4       = pc_plus4;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count    <= '0;
         redirect_count <= '0;
      end else if (handshake) begin
         fetch_count <= fetch_count + 32'd1;
         if (bus.jump || bus.pc_source)
            redirect_count <= redirect_count + 32'd1;
      end
   end
`else
   // Without counters the handshake term has no consumer.
   logic unused_handshake;
   assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (RESET_PC = 0x0040_0000).
// Build with +define+FETCH_PERF_CNT_EN to also exercise the performance counters.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic clk;
   logic reset;
   int   checks;
   int   fails;

   instr_fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] redirect_count;
`endif

   instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus.master)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count    (fetch_count),
      .redirect_count (redirect_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Stimulus helpers: all entered and exited at a negedge.
   task automatic do_reset();
      reset = 1'b1;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.instr_ready    = 1'b0;
      bus.pc_source      = 1'b0;
      bus.jump           = 1'b0;
      bus.branch_imm     = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic fetch_to_full(input logic [31:0] data);
      int n = 0;
      while (!bus.imem_req_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.imem_req_valid) begin
         checks++;
         fails++;
         $display("FAIL fetch_req_timeout: imem_req_valid=%0b after %0d cycles, expected 1", bus.imem_req_valid, n);
      end
      bus.imem_req_ready = 1'b1;
      @(negedge clk);
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = data;
      @(negedge clk);
      bus.imem_rsp_valid = 1'b0;
   endtask

   task automatic handshake(input logic j, input logic ps, input logic [31:0] imm);
      bus.jump        = j;
      bus.pc_source   = ps;
      bus.branch_imm  = imm;
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      bus.jump        = 1'b0;
      bus.pc_source   = 1'b0;
      bus.branch_imm  = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.instr_ready    = 1'b0;
      bus.pc_source      = 1'b0;
      bus.jump           = 1'b0;
      bus.branch_imm     = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.imem_req_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_req_valid: got %0b expected 0", bus.imem_req_valid);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RST_PC) begin
         fails++;
         $display("FAIL reset_first_req: valid=%0b addr=%h expected 1 %h", bus.imem_req_valid, bus.imem_addr, RST_PC);
      end
      checks++;
      if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || bus.op !== 6'h0 || bus.funct !== 6'h0) begin
         fails++;
         $display("FAIL reset_instr: valid=%0b instr=%h op=%h funct=%h expected all 0",
                  bus.instr_valid, bus.instr, bus.op, bus.funct);
      end
      checks++;
      if (bus.pc_plus4 !== RST_PC + 32'd4) begin
         fails++;
         $display("FAIL reset_pc_plus4: got %h expected %h", bus.pc_plus4, RST_PC + 32'd4);
      end
   endtask

   // Memory always ready, response one cycle after accept, decode always ready.
   task automatic test_sequential();
      logic [31:0] data [3];
      int pulses = 0;
      data[0] = 32'h012A_4020;
      data[1] = 32'h8D28_0004;
      data[2] = 32'h1109_FFFE;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      for (int c = 0; c < 9; c++) begin
         if (bus.instr_valid === 1'b1) pulses++;
         checks++;
         if (bus.imem_req_valid !== (c % 3 == 0) || bus.instr_valid !== (c % 3 == 2)) begin
            fails++;
            $display("FAIL seq_phase c=%0d: req_valid=%0b instr_valid=%0b expected %0b %0b",
                     c, bus.imem_req_valid, bus.instr_valid, (c % 3 == 0), (c % 3 == 2));
         end
         if (c % 3 == 0) begin
            checks++;
            if (bus.imem_addr !== RST_PC + 32'(4 * (c / 3))) begin
               fails++;
               $display("FAIL seq_addr c=%0d: got %h expected %h", c, bus.imem_addr, RST_PC + 32'(4 * (c / 3)));
            end
         end
         if (c % 3 == 2) begin
            checks++;
            if (bus.instr !== data[c / 3] || bus.op !== data[c / 3][31:26] || bus.funct !== data[c / 3][5:0]) begin
               fails++;
               $display("FAIL seq_instr c=%0d: instr=%h op=%h funct=%h expected %h", c, bus.instr, bus.op, bus.funct, data[c / 3]);
            end
         end
         bus.imem_rsp_valid = (c % 3 == 1);
         bus.imem_rsp_data  = data[c / 3];
         @(negedge clk);
      end
      bus.imem_req_ready = 1'b0;
      bus.instr_ready    = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      checks++;
      if (pulses != 3) begin
         fails++;
         $display("FAIL seq_valid_rate: %0d instr_valid cycles, expected 3", pulses);
      end
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0040_000C) begin
         fails++;
         $display("FAIL seq_next_addr: valid=%0b addr=%h expected 1 0040000c", bus.imem_req_valid, bus.imem_addr);
      end
   endtask

   task automatic test_branch();
      fetch_to_full({6'h02, 26'h40});
      handshake(1'b1, 1'b0, 32'h0);
      checks++;
      if (bus.imem_addr !== 32'h0000_0100) begin
         fails++;
         $display("FAIL jump_to_100: addr=%h expected 00000100", bus.imem_addr);
      end
      fetch_to_full(32'h1109_FFFE);
      checks++;
      if (bus.pc_plus4 !== 32'h0000_0104 || bus.op !== 6'h04) begin
         fails++;
         $display("FAIL branch_full: pc_plus4=%h op=%h expected 00000104 04", bus.pc_plus4, bus.op);
      end
      handshake(1'b0, 1'b1, 32'hFFFF_FFFE);
      checks++;
      if (bus.imem_addr !== 32'h0000_00FC) begin
         fails++;
         $display("FAIL branch_back: addr=%h expected 000000fc", bus.imem_addr);
      end
   endtask

   task automatic test_jump_priority();
      fetch_to_full(32'h0000_0000);
      handshake(1'b0, 1'b1, 32'h03FF_FFC2);
      checks++;
      if (bus.imem_addr !== 32'h1000_0008) begin
         fails++;
         $display("FAIL branch_far: addr=%h expected 10000008", bus.imem_addr);
      end
      fetch_to_full({6'h02, 26'h40});
      checks++;
      if (bus.pc_plus4 !== 32'h1000_000C) begin
         fails++;
         $display("FAIL jump_pc_plus4: got %h expected 1000000c", bus.pc_plus4);
      end
      handshake(1'b1, 1'b1, 32'h0000_0010);
      checks++;
      if (bus.imem_addr !== 32'h1000_0100) begin
         fails++;
         $display("FAIL jump_priority: addr=%h expected 10000100", bus.imem_addr);
      end
   endtask

   task automatic test_stall();
      fetch_to_full(32'h012A_4020);
      for (int i = 0; i < 5; i++) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = 32'hDEAD_BEEF;
         @(negedge clk);
         checks++;
         if (bus.instr !== 32'h012A_4020 || bus.op !== 6'h00 || bus.funct !== 6'h20 ||
             bus.instr_valid !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold i=%0d: instr=%h op=%h funct=%h valid=%0b req=%0b expected 012a4020 00 20 1 0",
                     i, bus.instr, bus.op, bus.funct, bus.instr_valid, bus.imem_req_valid);
         end
      end
      bus.imem_rsp_valid = 1'b0;
      handshake(1'b0, 1'b0, 32'h0);
      checks++;
      if (bus.imem_addr !== 32'h1000_0104 || bus.instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL stall_release: addr=%h valid=%0b expected 10000104 0", bus.imem_addr, bus.instr_valid);
      end
   endtask

   task automatic test_req_hold_reset_wrap();
      logic [31:0] addr0;
      addr0 = bus.imem_addr;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== addr0) begin
            fails++;
            $display("FAIL req_hold i=%0d: valid=%0b addr=%h expected 1 %h", i, bus.imem_req_valid, bus.imem_addr, addr0);
         end
      end
      bus.imem_req_ready = 1'b1;
      @(negedge clk);
      bus.imem_req_ready = 1'b0;
      checks++;
      if (bus.imem_req_valid !== 1'b0) begin
         fails++;
         $display("FAIL wait_no_req: valid=%0b expected 0", bus.imem_req_valid);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.imem_rsp_valid = 1'b0;
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RST_PC ||
          bus.instr_valid !== 1'b0 || bus.instr !== 32'h0) begin
         fails++;
         $display("FAIL reset_in_wait: req=%0b addr=%h valid=%0b instr=%h expected 1 %h 0 0",
                  bus.imem_req_valid, bus.imem_addr, bus.instr_valid, bus.instr, RST_PC);
      end
      fetch_to_full(32'h0000_0000);
      handshake(1'b0, 1'b1, 32'h3FEF_FFFE);
      checks++;
      if (bus.imem_addr !== 32'hFFFF_FFFC) begin
         fails++;
         $display("FAIL branch_to_top: addr=%h expected fffffffc", bus.imem_addr);
      end
      fetch_to_full(32'h0000_0000);
      checks++;
      if (bus.pc_plus4 !== 32'h0000_0000) begin
         fails++;
         $display("FAIL wrap_pc_plus4: got %h expected 00000000", bus.pc_plus4);
      end
      handshake(1'b0, 1'b0, 32'h0);
      checks++;
      if (bus.imem_addr !== 32'h0000_0000 || bus.imem_addr[1:0] !== 2'b00) begin
         fails++;
         $display("FAIL wrap_addr: addr=%h expected 00000000", bus.imem_addr);
      end
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         fetch_to_full(32'h012A_4020);
         handshake(1'b0, 1'b0, 32'h0);
      end
      fetch_to_full({6'h02, 26'h40});
      handshake(1'b1, 1'b0, 32'h0);
      checks++;
      if (fetch_count !== 32'd4 || redirect_count !== 32'd1) begin
         fails++;
         $display("FAIL perf_counts: fetch=%0d redirect=%0d expected 4 1", fetch_count, redirect_count);
      end
      do_reset();
      checks++;
      if (fetch_count !== 32'd0 || redirect_count !== 32'd0) begin
         fails++;
         $display("FAIL perf_reset: fetch=%0d redirect=%0d expected 0 0", fetch_count, redirect_count);
      end
   endtask
`endif

   initial begin
      checks = 0;
      fails  = 0;
      @(negedge clk);
      test_reset();
      test_sequential();
      test_branch();
      test_jump_priority();
      test_stall();
      test_req_hold_reset_wrap();
`ifdef FETCH_PERF_CNT_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
